// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and stage-mask helpers for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

  // Per-cycle controller mode, listed from highest to lowest priority.
  typedef enum logic [2:0] {
    CM_HARD,
    CM_EXC,
    CM_STQ,
    CM_HAZ,
    CM_REDIR,
    CM_RUN
  } ctrl_mode_e;

  // Upper bound on pipeline depth; stage masks are built at this width and
  // then trimmed to the real stage count by the controller.
  localparam int unsigned MAX_STAGES = 32;

  typedef logic [MAX_STAGES-1:0] stage_mask_t;

  // Write-enable and bubble-insert masks for every pipeline register.
  typedef struct packed {
    stage_mask_t wr;
    stage_mask_t flush;
  } stage_ctl_t;

  // Bits lo..hi set, everything else clear.
  function automatic stage_mask_t range_mask(int unsigned lo, int unsigned hi);
    stage_mask_t m;
    m = '0;
    for (int unsigned i = 0; i < MAX_STAGES; i++) begin
      if (i >= lo && i <= hi) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Stages 0..k hold, stage k+1 takes a bubble, older stages keep draining.
  function automatic stage_ctl_t hold_below(int unsigned k);
    stage_ctl_t c;
    c.flush = range_mask(k + 1, k + 1);
    c.wr    = ~range_mask(0, k);
    return c;
  endfunction

  // Stages lo..hi are squashed; every other stage writes normally.
  function automatic stage_ctl_t flush_range(int unsigned lo, int unsigned hi);
    stage_ctl_t c;
    c.flush = range_mask(lo, hi);
    c.wr    = ~c.flush;
    return c;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline's hazard/cache sources and the controller.
interface pipe_hazard_ctrl_if #(
  parameter int NUM_STAGES = 7,
  parameter int ADDR_W     = 32
);
  localparam int DEPTH_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  // Stall, flush and redirect sources
  logic                  hard_stall_i;
  logic                  exc_flush_i;
  logic                  redirect_i;
  logic [DEPTH_W-1:0]    redirect_depth_i;
  logic [NUM_STAGES-1:0] hazard_stall_i;

  // Load request at the exception/memory stage
  logic                  ld_req_i;
  logic                  ld_cached_i;
  logic [ADDR_W-1:0]     ld_addr_i;

  // Store traffic into the cache write path
  logic                  st_push_i;
  logic                  st_cached_i;
  logic [ADDR_W-1:0]     st_addr_i;
  logic                  st_pop_i;

  // Pipeline register control
  logic [NUM_STAGES-1:0] stage_wr_o;
  logic [NUM_STAGES-1:0] stage_flush_o;

  // Cache control and status
  logic                  icache_flush_o;
  logic                  ireq_valid_o;
  logic                  dreq_valid_o;
  logic                  icache_stall_o;
  logic                  dcache_stall_o;
  logic                  stq_full_o;
  logic                  stq_ovf_o;
  logic                  wdog_o;

  // Pipeline side: drives the requests, observes the controls.
  modport master (
    output hard_stall_i, exc_flush_i, redirect_i, redirect_depth_i, hazard_stall_i,
           ld_req_i, ld_cached_i, ld_addr_i,
           st_push_i, st_cached_i, st_addr_i, st_pop_i,
    input  stage_wr_o, stage_flush_o, icache_flush_o, ireq_valid_o, dreq_valid_o,
           icache_stall_o, dcache_stall_o, stq_full_o, stq_ovf_o, wdog_o
  );

  // Controller side.
  modport slave (
    input  hard_stall_i, exc_flush_i, redirect_i, redirect_depth_i, hazard_stall_i,
           ld_req_i, ld_cached_i, ld_addr_i,
           st_push_i, st_cached_i, st_addr_i, st_pop_i,
    output stage_wr_o, stage_flush_o, icache_flush_o, ireq_valid_o, dreq_valid_o,
           icache_stall_o, dcache_stall_o, stq_full_o, stq_ovf_o, wdog_o
  );

endinterface

// File: rtl/pipe_hazard_ctrl_stq.sv
// Store-line tracker: in-order FIFO of cache line tags for stores still in
// flight to the D-cache array, with a parallel compare against a load's tag.
// Entry 0 is always the oldest; a pop shifts the queue down by one.
module stq_line_tracker #(
  parameter int DEPTH = 2,
  parameter int TAG_W = 28
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [TAG_W-1:0] push_tag_i,
  input  logic             pop_i,
  input  logic [TAG_W-1:0] cmp_tag_i,
  output logic             hit_o,
  output logic             full_o,
  output logic             ovf_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [TAG_W-1:0] tags_q [DEPTH];
  logic [TAG_W-1:0] tags_d [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] wr_idx;
  logic             ovf_q, ovf_d;
  logic             full;
  logic             pop_ok;
  logic             push_ok;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign pop_ok  = pop_i && (cnt_q != '0);
  // A push into a full tracker still lands when the oldest entry leaves in
  // the same cycle.
  assign push_ok = push_i && (!full || pop_ok);
  assign wr_idx  = pop_ok ? (cnt_q - CNT_W'(1)) : cnt_q;

  // Next queue contents: shift on pop, then append the new tag behind the
  // surviving entries.
  // NOTE: every variable written in an always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    tags_d = tags_q;
    if (pop_ok) begin
      for (int i = 0; i < DEPTH - 1; i++) tags_d[i] = tags_q[i + 1];
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (push_ok && (CNT_W'(i) == wr_idx)) tags_d[i] = push_tag_i;
    end
    cnt_d = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    ovf_d = ovf_q | (push_i && full && !pop_ok);
  end

  // Conflict compare against the registered entries only, so an entry that
  // is popping this cycle still blocks a load to its line this cycle.
  always_comb begin
    hit_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < cnt_q) && (tags_q[i] == cmp_tag_i)) hit_o = 1'b1;
    end
  end

  // Occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // Tag storage.
  // NOTE: tag storage has no reset; an entry is only ever read when the count
  // marks it valid, so clearing it would buy nothing.
  always_ff @(posedge clk) begin
    tags_q <= tags_d;
  end

  assign full_o = full;
  assign ovf_o  = ovf_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller: resolves hard stalls, exceptions,
// store-line conflicts, data hazards and redirects into per-stage write and
// bubble controls, and runs a watchdog on the writeback stage.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = 7,
  parameter int EXC_STAGE  = 3,
  parameter int STQ_DEPTH  = 2,
  parameter int ADDR_W     = 32,
  parameter int LINE_OFF_W = 4,
  parameter int WDOG_W     = 16
) (
  input  logic            clk,
  input  logic            rst,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int TAG_W = ADDR_W - LINE_OFF_W;

  ctrl_mode_e            mode;
  stage_ctl_t            ctl;
  logic                  exc_pend_q, exc_pend_d;
  logic [WDOG_W-1:0]     wdog_q, wdog_d;
  logic                  haz_any;
  int unsigned           haz_k;
  int unsigned           redir_d;
  logic                  stq_hit, stq_full, stq_ovf;
  logic                  st_push, st_pop;
  logic                  icache_flush, ireq_valid, dreq_valid;
  logic                  icache_stall, dcache_stall;
  logic [NUM_STAGES-1:0] stage_wr;
  logic                  unused_bits;

  // Nothing moves through the tracker while the pipeline is hard-stalled.
  assign st_push = bus.st_push_i && bus.st_cached_i && !bus.hard_stall_i;
  assign st_pop  = bus.st_pop_i && !bus.hard_stall_i;

  stq_line_tracker #(
    .DEPTH (STQ_DEPTH),
    .TAG_W (TAG_W)
  ) u_stq (
    .clk        (clk),
    .rst        (rst),
    .push_i     (st_push),
    .push_tag_i (bus.st_addr_i[ADDR_W-1:LINE_OFF_W]),
    .pop_i      (st_pop),
    .cmp_tag_i  (bus.ld_addr_i[ADDR_W-1:LINE_OFF_W]),
    .hit_o      (stq_hit),
    .full_o     (stq_full),
    .ovf_o      (stq_ovf)
  );

  // Find the oldest stage asking for a data-hazard stall; the end stages
  // never stall on their own.
  always_comb begin
    haz_any = 1'b0;
    haz_k   = 0;
    for (int i = 1; i <= NUM_STAGES - 2; i++) begin
      if (bus.hazard_stall_i[i]) begin
        haz_any = 1'b1;
        haz_k   = unsigned'(i);
      end
    end
  end

  // Clamp the redirect flush depth to 1..EXC_STAGE.
  always_comb begin
    redir_d = 32'(bus.redirect_depth_i);
    if (redir_d == 0) redir_d = 1;
    if (redir_d > unsigned'(EXC_STAGE)) redir_d = unsigned'(EXC_STAGE);
  end

  // Strict-priority mode decode.
  always_comb begin
    if (bus.hard_stall_i)
      mode = CM_HARD;
    else if (bus.exc_flush_i || exc_pend_q)
      mode = CM_EXC;
    else if (bus.ld_req_i && ((bus.ld_cached_i && stq_hit) || stq_full))
      mode = CM_STQ;
    else if (haz_any)
      mode = CM_HAZ;
    else if (bus.redirect_i)
      mode = CM_REDIR;
    else
      mode = CM_RUN;
  end

  // Stage and cache controls for the selected mode; reset overrides all.
  always_comb begin
    ctl          = '{wr: '1, flush: '0};
    icache_flush = 1'b0;
    ireq_valid   = 1'b0;
    dreq_valid   = 1'b0;
    icache_stall = 1'b0;
    dcache_stall = 1'b0;
    unique case (mode)
      CM_HARD: begin
        ctl.wr       = '0;
        icache_stall = 1'b1;
        dcache_stall = 1'b1;
      end
      CM_EXC: begin
        ctl          = flush_range(1, unsigned'(EXC_STAGE));
        icache_flush = 1'b1;
      end
      CM_STQ: begin
        ctl          = hold_below(unsigned'(EXC_STAGE));
        icache_stall = 1'b1;
      end
      CM_HAZ: begin
        ctl          = hold_below(haz_k);
        dreq_valid   = 1'b1;
        icache_stall = 1'b1;
      end
      CM_REDIR: begin
        ctl          = flush_range(1, redir_d);
        icache_flush = 1'b1;
        dreq_valid   = 1'b1;
      end
      default: begin
        ireq_valid = 1'b1;
        dreq_valid = 1'b1;
      end
    endcase
    if (rst) begin
      ctl.wr       = '0;
      ctl.flush    = '1;
      icache_flush = 1'b0;
      ireq_valid   = 1'b0;
      dreq_valid   = 1'b0;
      icache_stall = 1'b0;
      dcache_stall = 1'b0;
    end
  end

  assign stage_wr = ctl.wr[NUM_STAGES-1:0];

  // Next state: an exception seen under a hard stall waits until the stall
  // drops; the watchdog counts cycles in which writeback does not advance.
  always_comb begin
    exc_pend_d = bus.hard_stall_i && (exc_pend_q || bus.exc_flush_i);
    if (stage_wr[NUM_STAGES-1])
      wdog_d = '0;
    else if (&wdog_q)
      wdog_d = wdog_q;
    else
      wdog_d = wdog_q + WDOG_W'(1);
  end

  // State registers.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the values from before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      exc_pend_q <= 1'b0;
      wdog_q     <= '0;
    end else begin
      exc_pend_q <= exc_pend_d;
      wdog_q     <= wdog_d;
    end
  end

  assign bus.stage_wr_o     = stage_wr;
  assign bus.stage_flush_o  = ctl.flush[NUM_STAGES-1:0];
  assign bus.icache_flush_o = icache_flush;
  assign bus.ireq_valid_o   = ireq_valid;
  assign bus.dreq_valid_o   = dreq_valid;
  assign bus.icache_stall_o = icache_stall;
  assign bus.dcache_stall_o = dcache_stall;
  assign bus.stq_full_o     = stq_full;
  assign bus.stq_ovf_o      = stq_ovf;
  assign bus.wdog_o         = !rst && (&wdog_q);

  // Mask bits beyond the real pipeline, the ignored end-stage hazard bits and
  // the line-offset address bits carry no meaning here.
  assign unused_bits = ^{ctl.wr[MAX_STAGES-1:NUM_STAGES],
                         ctl.flush[MAX_STAGES-1:NUM_STAGES],
                         bus.hazard_stall_i[0], bus.hazard_stall_i[NUM_STAGES-1],
                         bus.ld_addr_i[LINE_OFF_W-1:0], bus.st_addr_i[LINE_OFF_W-1:0]};

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (7 stages, MEM at stage 3, 2-entry
// tracker, 10-bit watchdog so saturation is reached quickly).
module tb_pipe_hazard_ctrl;

  localparam int NS = 7;
  localparam int EX = 3;
  localparam int SD = 2;
  localparam int AW = 32;
  localparam int LO = 4;
  localparam int WW = 10;

  logic clk = 1'b0;
  logic rst;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.NUM_STAGES(NS), .ADDR_W(AW)) bus ();

  pipe_hazard_ctrl #(
    .NUM_STAGES (NS),
    .EXC_STAGE  (EX),
    .STQ_DEPTH  (SD),
    .ADDR_W     (AW),
    .LINE_OFF_W (LO),
    .WDOG_W     (WW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic [NS-1:0] wr, input logic [NS-1:0] fl);
    check({tag, ".wr"}, 32'(bus.stage_wr_o), 32'(wr));
    check({tag, ".flush"}, 32'(bus.stage_flush_o), 32'(fl));
  endtask

  // {icache_flush, ireq, dreq, icache_stall, dcache_stall}
  task automatic chk_cache(input string tag, input logic [4:0] exp);
    check({tag, ".cache"}, 32'({bus.icache_flush_o, bus.ireq_valid_o, bus.dreq_valid_o,
                                bus.icache_stall_o, bus.dcache_stall_o}), 32'(exp));
  endtask

  task automatic idle();
    bus.hard_stall_i     = 1'b0;
    bus.exc_flush_i      = 1'b0;
    bus.redirect_i       = 1'b0;
    bus.redirect_depth_i = '0;
    bus.hazard_stall_i   = '0;
    bus.ld_req_i         = 1'b0;
    bus.ld_cached_i      = 1'b0;
    bus.ld_addr_i        = '0;
    bus.st_push_i        = 1'b0;
    bus.st_cached_i      = 1'b0;
    bus.st_addr_i        = '0;
    bus.st_pop_i         = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic cached);
    bus.ld_req_i    = 1'b1;
    bus.ld_cached_i = cached;
    bus.ld_addr_i   = a;
  endtask

  task automatic store(input logic [AW-1:0] a, input logic cached);
    bus.st_push_i   = 1'b1;
    bus.st_cached_i = cached;
    bus.st_addr_i   = a;
  endtask

  initial begin
    // Reset forcing
    idle();
    rst = 1'b1;
    tick(); tick();
    chk_st("reset", 7'h00, 7'h7F);
    chk_cache("reset", 5'b00000);
    check("reset.wdog", 32'(bus.wdog_o), 32'd0);
    check("reset.stq", 32'({bus.stq_full_o, bus.stq_ovf_o}), 32'd0);
    rst = 1'b0;
    #1;
    chk_st("run", 7'h7F, 7'h00);
    chk_cache("run", 5'b01100);
    tick();

    // Redirects, including depth clamping at both ends
    bus.redirect_i = 1'b1; bus.redirect_depth_i = 3'd2;
    #1;
    chk_st("redir2", 7'b1111001, 7'b0000110);
    chk_cache("redir2", 5'b10100);
    bus.redirect_depth_i = 3'd0;
    #1;
    chk_st("redir0", 7'b1111101, 7'b0000010);
    bus.redirect_depth_i = 3'd6;
    #1;
    chk_st("redir6", 7'b1110001, 7'b0001110);
    idle(); tick();

    // Data hazards
    bus.hazard_stall_i = 7'b0000100;
    #1;
    chk_st("haz2", 7'b1111000, 7'b0001000);
    chk_cache("haz2", 5'b00110);
    bus.hazard_stall_i = 7'b0001010; bus.redirect_i = 1'b1; bus.redirect_depth_i = 3'd2;
    #1;
    chk_st("haz3_over_redir", 7'b1110000, 7'b0010000);
    bus.hazard_stall_i = 7'b1000001; bus.redirect_i = 1'b0;
    #1;
    chk_st("haz_ends_ignored", 7'h7F, 7'h00);
    idle(); tick();

    // Exception held pending through a 3-cycle hard stall
    bus.hard_stall_i = 1'b1; bus.exc_flush_i = 1'b1;
    #1;
    chk_st("hard_exc1", 7'h00, 7'h00);
    chk_cache("hard_exc1", 5'b00011);
    tick(); bus.exc_flush_i = 1'b0;
    #1;
    chk_st("hard_exc2", 7'h00, 7'h00);
    tick();
    chk_st("hard_exc3", 7'h00, 7'h00);
    tick(); bus.hard_stall_i = 1'b0;
    #1;
    chk_st("exc_applied", 7'b1110001, 7'b0001110);
    chk_cache("exc_applied", 5'b10000);
    tick();
    chk_st("exc_cleared", 7'h7F, 7'h00);

    // Reset mid-operation drops a pending exception
    bus.hard_stall_i = 1'b1; bus.exc_flush_i = 1'b1;
    tick();
    idle(); rst = 1'b1;
    #1;
    chk_st("rst_mid", 7'h00, 7'h7F);
    tick(); rst = 1'b0;
    #1;
    chk_st("rst_drops_pend", 7'h7F, 7'h00);
    tick();

    // Store-line tracker conflicts
    store(32'h8000_0010, 1'b1); load(32'h8000_001C, 1'b1);
    #1;
    chk_st("push_not_yet_visible", 7'h7F, 7'h00);
    tick();
    bus.st_addr_i = 32'h8000_0020; bus.ld_req_i = 1'b0;
    #1;
    check("stq_full_one", 32'(bus.stq_full_o), 32'd0);
    tick(); bus.st_push_i = 1'b0;
    #1;
    check("stq_full_two", 32'(bus.stq_full_o), 32'd1);
    load(32'h8000_001C, 1'b1);
    #1;
    chk_st("stq_hit", 7'b1110000, 7'b0010000);
    chk_cache("stq_hit", 5'b00010);
    load(32'h9000_0000, 1'b0);
    #1;
    chk_st("stq_full_load", 7'b1110000, 7'b0010000);
    load(32'h8000_001C, 1'b1); bus.st_pop_i = 1'b1;
    #1;
    chk_st("stq_pop_cycle", 7'b1110000, 7'b0010000);
    tick(); bus.st_pop_i = 1'b0;
    #1;
    chk_st("stq_after_pop", 7'h7F, 7'h00);
    check("stq_not_full", 32'(bus.stq_full_o), 32'd0);
    idle(); tick();

    // Overflow: push into a full tracker with no pop
    store(32'h8000_0030, 1'b1);
    tick(); bus.st_addr_i = 32'h8000_0040;
    #1;
    check("ovf_before", 32'({bus.stq_full_o, bus.stq_ovf_o}), 32'b10);
    tick(); bus.st_push_i = 1'b0;
    #1;
    check("ovf_set", 32'({bus.stq_full_o, bus.stq_ovf_o}), 32'b11);
    bus.st_pop_i = 1'b1;
    tick(); tick(); bus.st_pop_i = 1'b0;
    #1;
    check("ovf_sticky", 32'({bus.stq_full_o, bus.stq_ovf_o}), 32'b01);
    load(32'h8000_004C, 1'b1);
    #1;
    chk_st("dropped_not_tracked", 7'h7F, 7'h00);
    idle();

    // Uncached and hard-stalled stores are not tracked
    store(32'hA000_0000, 1'b0);
    tick(); idle(); load(32'hA000_0004, 1'b1);
    #1;
    chk_st("uncached_store", 7'h7F, 7'h00);
    idle(); bus.hard_stall_i = 1'b1; store(32'hB000_0000, 1'b1);
    tick(); idle(); load(32'hB000_0008, 1'b1);
    #1;
    chk_st("stalled_store", 7'h7F, 7'h00);

    // Pop on empty is ignored
    idle(); bus.st_pop_i = 1'b1;
    tick(); idle(); store(32'hC000_0000, 1'b1);
    tick(); idle(); load(32'hC000_0000, 1'b1);
    #1;
    chk_st("pop_empty_ignored", 7'b1110000, 7'b0010000);
    check("pop_empty_count", 32'(bus.stq_full_o), 32'd0);
    idle(); bus.st_pop_i = 1'b1;
    tick(); idle();

    // Overflow clears only on reset
    check("ovf_still_set", 32'(bus.stq_ovf_o), 32'd1);
    rst = 1'b1;
    tick(); rst = 1'b0;
    #1;
    check("ovf_reset", 32'(bus.stq_ovf_o), 32'd0);
    tick();

    // Watchdog saturation and release
    bus.hard_stall_i = 1'b1;
    #1;
    check("wdog_start", 32'(bus.wdog_o), 32'd0);
    repeat ((1 << WW) - 2) tick();
    check("wdog_one_short", 32'(bus.wdog_o), 32'd0);
    tick();
    check("wdog_saturated", 32'(bus.wdog_o), 32'd1);
    tick();
    check("wdog_holds", 32'(bus.wdog_o), 32'd1);
    bus.hard_stall_i = 1'b0;
    #1;
    check("wdog_release_cycle", 32'(bus.wdog_o), 32'd1);
    chk_st("wdog_release", 7'h7F, 7'h00);
    tick();
    check("wdog_cleared", 32'(bus.wdog_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised pipeline stall/flush controller. It sits beside the in-order pipeline, between the hazard, exception, branch and cache sources and the per-stage pipeline registers. It generalises the fixed seven-stage controller to N stages, and adds three things: a latched exception flush that survives a hard stall, a store-line tracker of configurable depth for load-after-store cache conflicts, and a stall watchdog.

## Interface
Parameters:
- NUM_STAGES, 7: number of pipeline registers, index 0 = PREIF … NUM_STAGES-1 = WB.
- EXC_STAGE, 3: stage that raises exceptions and issues D-cache requests (MEM).
- STQ_DEPTH, 2: entries in the store-line tracker.
- ADDR_W, 32: address width.
- LINE_OFF_W, 4: line offset bits; line tag is addr[ADDR_W-1:LINE_OFF_W].
- WDOG_W, 16: watchdog counter width.

Ports:
- clk  in  1  clock. Reset is synchronous and active-high on rst.
- rst  in  1  synchronous active-high reset.
- hard_stall_i  in  1  OR of I/D cache busy, I/D TLB stall and mul/div busy.
- exc_flush_i  in  1  exception taken at EXC_STAGE.
- redirect_i  in  1  front-end redirect (branch mispredict or immediate jump).
- redirect_depth_i  in  $clog2(NUM_STAGES)  youngest-to-oldest flush depth (1 = IF only).
- hazard_stall_i  in  NUM_STAGES  per-stage data-hazard stall; bits 0 and NUM_STAGES-1 are ignored.
- ld_req_i, ld_cached_i  in  1  cached load/store request present at EXC_STAGE.
- ld_addr_i  in  ADDR_W  its address.
- st_push_i, st_cached_i  in  1  store leaving EXC_STAGE into the cache write path.
- st_addr_i  in  ADDR_W  that store's address.
- st_pop_i  in  1  oldest tracked store written into the cache array.
- stage_wr_o  out  NUM_STAGES  pipeline register write enable.
- stage_flush_o  out  NUM_STAGES  pipeline register bubble insert.
- icache_flush_o, ireq_valid_o, dreq_valid_o  out  1  cache control.
- icache_stall_o, dcache_stall_o  out  1  hold the cache FSM's result until the CPU accepts it.
- stq_full_o  out  1  tracker full.
- stq_ovf_o  out  1  sticky: a push was attempted while the tracker was full.
- wdog_o  out  1  watchdog saturated.

## Operation
Modes (ctrl_mode_e), resolved each cycle in strict priority order:
- HARD (hard_stall_i):
  - all stage_wr = 0, no flush.
  - ireq/dreq_valid = 0; icache_stall = dcache_stall = 1.
  - If exc_flush_i is also high, set exc_pend.
- EXC (exc_flush_i or exc_pend):
  - Stage 0 writes.
  - Stages 1..EXC_STAGE are flushed (wr=0, flush=1).
  - Stages above EXC_STAGE write.
  - icache_flush = 1; req valids = 0; clear exc_pend.
- STQ (ld_req_i & ld_cached_i & line match on any valid tracker entry, or stq_full_o with ld_req_i):
  - Stages 0..EXC_STAGE hold.
  - Stage EXC_STAGE+1 gets a bubble (wr=1, flush=1).
  - Older stages write; ireq=dreq=0; icache_stall = 1.
- HAZ (highest set bit k of hazard_stall_i[NUM_STAGES-2:1]):
  - Stages 0..k hold; stage k+1 gets a bubble; older stages write.
  - dreq_valid = 1; icache_stall = 1.
- REDIR (redirect_i):
  - d = min(max(redirect_depth_i,1), EXC_STAGE).
  - Stage 0 writes; stages 1..d are flushed; the rest write.
  - icache_flush = 1; dreq_valid = 1.
- RUN: all stages write; ireq = dreq = 1.

Store-line tracker (FIFO of line tags):
- Push: st_push_i & st_cached_i & !hard_stall_i. Uncached stores are not tracked.
- Pop: st_pop_i & !hard_stall_i.
- Simultaneous push and pop when full: both succeed and the count is unchanged.
- Push when full: dropped, and stq_ovf_o is set (sticky).
- Pop when empty: ignored.
- Conflict compare uses the registered contents, so an entry popped this cycle still matches this cycle.
- Exceptions do not clear the tracker.

Watchdog:
- The counter increments, saturating, each cycle stage_wr_o[NUM_STAGES-1] = 0; otherwise it clears.
- wdog_o = counter at all ones.

Reset:
- exc_pend = 0, tracker empty, stq_ovf = 0, counter = 0.
- While rst is high, outputs are forced to: stage_wr = 0, stage_flush = all ones, all cache outputs 0, wdog_o = 0.

## Timing
- Mode decode and all stage/cache outputs are combinational from inputs and registered state; zero-cycle latency.
- A pending exception flush is applied on the first cycle hard_stall_i is low, then clears. exc_flush_i arriving while exc_pend is set adds nothing.
- A tracker push is visible to the conflict compare on the next cycle. Pop takes effect on the next cycle.
- stq_full_o is registered (count == STQ_DEPTH).
- Reset mid-operation: all state clears at the next clock edge, including a pending exception.

## Structure
- pipe_ctrl_pkg:
  - ctrl_mode_e {CM_HARD, CM_EXC, CM_STQ, CM_HAZ, CM_REDIR, CM_RUN}.
  - Helper function that builds the stage masks (hold-below/bubble-at) from a stage index.
- Sub-module stq_line_tracker: parametrised FIFO with a parallel tag compare. Outputs hit, full and ovf.
- Top level: priority decode, exc_pend register, watchdog.

## Test plan
- RUN, then redirect_i with depth 2 → stage_wr = 7'b1111001, stage_flush = 7'b0000110, icache_flush = 1.
- exc_flush_i with hard_stall_i for 3 cycles:
  - During the stall: all stage_wr = 0.
  - Cycle after the stall drops: EXC mask stage_flush = 7'b0001110, exc_pend clears.
- Push stores to 0x8000_0010 and 0x8000_0020 (full), then load 0x8000_001C:
  - STQ stall with stage_wr = 7'b1110000 and stage_flush bit 4 set.
  - Stall persists through the pop cycle and clears the cycle after.
- Third push while full, with no pop → stq_ovf_o = 1 and stays 1 until rst.
- hazard_stall_i = 7'b0000100 → stage_wr = 7'b1111000, stage_flush = 7'b0001000, dreq_valid = 1, ireq_valid = 0.
- hard_stall_i held for 2^WDOG_W cycles → wdog_o rises exactly at saturation and falls the cycle after the stall releases.
